// File: rtl/project_cfg_pkg.sv
// Shared configuration for the board-to-board link: FSM state types and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package project_cfg_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;
    localparam int DEFAULT_MAX_RETRIES    = 3;
    localparam int DEFAULT_SYNC_STAGES    = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_REQ,
        TX_REL,
        TX_GAP,
        TX_ERR
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous control line.
// Latency: SYNC_STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (async, active high), d (async input), q (synchronised output).
module sync_bit
    import project_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two stages gives no metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/board_link.sv
// Full-duplex 4-phase req/ack link between two boards with alternating-bit sequence, timeout and retry.
// Latency: remote req edge -> ack SYNC_STAGES+1 cycles, -> rx_valid SYNC_STAGES+2 cycles.
// Backpressure: tx_ready only in idle; rx has none (rx_valid is a strobe, rx_data held until next strobe).
// Ports: tx_valid/tx_data/tx_ready local send; rx_valid/rx_data local receive;
//        link_* to/from the peer; busy, sticky error, err_clr.
module board_link
    import project_cfg_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEFAULT_MAX_RETRIES,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH:0]   link_data_out,
    output logic                  link_req_out,
    input  logic                  link_ack_in,
    input  logic [DATA_WIDTH:0]   link_data_in,
    input  logic                  link_req_in,
    output logic                  link_ack_out,
    output logic                  busy,
    output logic                  error,
    input  logic                  err_clr
);

    localparam int TIMER_W = cnt_width(TIMEOUT_CYCLES);
    localparam int RETRY_W = cnt_width(MAX_RETRIES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    logic ack_sync;
    logic req_sync;
    logic req_sync_q;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (link_ack_in),
        .q   (ack_sync)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (link_req_in),
        .q   (req_sync)
    );

    // ------------------------------------------------------------------ TX
    tx_state_t          tx_state;
    logic [TIMER_W-1:0] tx_timer;
    logic [RETRY_W-1:0] tx_retries;
    logic               tx_seq;
    logic               timer_done;
    logic               phase_timeout;

    // Timer value TIMER_LAST means the current state has lasted TIMEOUT_CYCLES cycles.
    assign timer_done    = (tx_timer == TIMER_LAST);
    assign phase_timeout = timer_done &&
                           (((tx_state == TX_REQ) && !ack_sync) ||
                            ((tx_state == TX_REL) &&  ack_sync));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state      <= TX_IDLE;
            tx_timer      <= '0;
            tx_retries    <= '0;
            tx_seq        <= 1'b0;
            tx_ready      <= 1'b0;
            link_data_out <= '0;
            link_req_out  <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
        end else begin
            // Saturating phase timer; every state change below restarts it.
            if (!timer_done) begin
                tx_timer <= tx_timer + TIMER_W'(1);
            end

            case (tx_state)
                TX_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_seq        <= ~tx_seq;
                        link_data_out <= {~tx_seq, tx_data};
                        tx_retries    <= '0;
                        tx_ready      <= 1'b0;
                        busy          <= 1'b1;
                        tx_timer      <= '0;
                        tx_state      <= TX_SETUP;
                    end
                end
                // One cycle of data ahead of req gives the peer setup margin.
                TX_SETUP: begin
                    link_req_out <= 1'b1;
                    tx_timer     <= '0;
                    tx_state     <= TX_REQ;
                end
                TX_REQ: begin
                    if (ack_sync) begin
                        link_req_out <= 1'b0;
                        tx_timer     <= '0;
                        tx_state     <= TX_REL;
                    end
                end
                TX_REL: begin
                    if (!ack_sync) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        tx_timer <= '0;
                        tx_state <= TX_IDLE;
                    end
                end
                // Retransmission reuses link_data_out untouched: same seq, same payload.
                TX_GAP: begin
                    if (timer_done) begin
                        tx_timer <= '0;
                        tx_state <= TX_SETUP;
                    end
                end
                TX_ERR: begin
                    if (err_clr) begin
                        error      <= 1'b0;
                        tx_retries <= '0;
                        tx_ready   <= 1'b1;
                        tx_timer   <= '0;
                        tx_state   <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase

            if (phase_timeout) begin
                link_req_out <= 1'b0;
                tx_timer     <= '0;
                if (tx_retries == RETRY_MAX) begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    tx_state <= TX_ERR;
                end else begin
                    tx_retries <= tx_retries + RETRY_W'(1);
                    tx_state   <= TX_GAP;
                end
            end
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_t         rx_state;
    logic              rx_pend;
    logic [DATA_WIDTH:0] rx_sample;
    logic              rx_last_seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            req_sync_q   <= 1'b0;
            rx_pend      <= 1'b0;
            rx_sample    <= '0;
            rx_last_seq  <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            link_ack_out <= 1'b0;
        end else begin
            req_sync_q <= req_sync;
            rx_valid   <= 1'b0;
            rx_pend    <= 1'b0;

            // A repeated seq is a retransmission of something already delivered.
            if (rx_pend && (rx_sample[DATA_WIDTH] != rx_last_seq)) begin
                rx_valid    <= 1'b1;
                rx_data     <= rx_sample[DATA_WIDTH-1:0];
                rx_last_seq <= rx_sample[DATA_WIDTH];
            end

            case (rx_state)
                RX_IDLE: begin
                    if (req_sync && !req_sync_q) begin
                        rx_sample    <= link_data_in;
                        rx_pend      <= 1'b1;
                        link_ack_out <= 1'b1;
                        rx_state     <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!req_sync) begin
                        link_ack_out <= 1'b0;
                        rx_state     <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
